dmx8_32bits_reg: RTL and testbench

DMX8_32BITS_REG -- requirements
Module: dmx8_32bits_reg

---
 rtl/dmx8_32bits_reg.sv | 96 +++++++++
 tb/tb_dmx8_32bits_reg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmx8_32bits_reg.sv
// dmx8_32bits_reg: 1-to-8 demultiplexer into eight 32-bit holding registers.
// Each channel holds one word until its consumer acks it. The destination is
// either sel or an internal round-robin pointer. A sticky err flags acks
// that arrive at an empty channel.
module dmx8_32bits_reg (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] d,
   input  logic [2:0]  sel,
   input  logic        rr_en,
   input  logic [7:0]  ack,
   output logic [31:0] y0,
   output logic [31:0] y1,
   output logic [31:0] y2,
   output logic [31:0] y3,
   output logic [31:0] y4,
   output logic [31:0] y5,
   output logic [31:0] y6,
   output logic [31:0] y7,
   output logic [7:0]  vld,
   output logic [2:0]  ptr,
   output logic        err
);

   logic [31:0] y_q [8];
   logic [2:0]  dst;
   logic        accept;
   logic [7:0]  load_mask;

   // Destination select, readiness and one-hot load mask. in_ready depends only
   // on registered vld, so an ack cannot free a channel within the same cycle.
   always_comb begin
      dst       = rr_en ? ptr : sel;
      in_ready  = ~vld[dst];
      accept    = in_valid & in_ready;
      load_mask = '0;
      if (accept) begin
         load_mask[dst] = 1'b1;
      end
   end

   // Data registers: load only the addressed channel; otherwise hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < 8; i++) begin
            y_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 8; i++) begin
            if (load_mask[i]) begin
               y_q[i] <= d;
            end
         end
      end
   end

   // Valid flags. An ack clears its own bit. A load sets its bit. A load can
   // only target an empty channel, so the two never conflict on a live word.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
      end else begin
         vld <= (vld & ~ack) | load_mask;
      end
   end

   // Round-robin pointer advances only on words accepted in round-robin mode.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (accept && rr_en) begin
         ptr <= ptr + 3'd1;
      end
   end

   // Sticky error: any ack aimed at a channel that holds no word.
   always_ff @(posedge clk) begin
      if (reset) begin
         err <= 1'b0;
      end else if (|(ack & ~vld)) begin
         err <= 1'b1;
      end
   end

   assign y0 = y_q[0];
   assign y1 = y_q[1];
   assign y2 = y_q[2];
   assign y3 = y_q[3];
   assign y4 = y_q[4];
   assign y5 = y_q[5];
   assign y6 = y_q[6];
   assign y7 = y_q[7];

endmodule

// File: tb/tb_dmx8_32bits_reg.sv
// Testbench for dmx8_32bits_reg: directed scenarios. A behavioural channel
// model is checked against the DUT every cycle. Literal expectations pin
// down key points of each scenario.
module tb_dmx8_32bits_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] d;
   logic [2:0]  sel;
   logic        rr_en;
   logic [7:0]  ack;
   logic [31:0] y0, y1, y2, y3, y4, y5, y6, y7;
   logic [7:0]  vld;
   logic [2:0]  ptr;
   logic        err;
   logic [31:0] ys [8];

   int total = 0;
   int bad   = 0;

   dmx8_32bits_reg dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .d(d), .sel(sel), .rr_en(rr_en), .ack(ack),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
      .vld(vld), .ptr(ptr), .err(err)
   );

   assign ys[0] = y0;
   assign ys[1] = y1;
   assign ys[2] = y2;
   assign ys[3] = y3;
   assign ys[4] = y4;
   assign ys[5] = y5;
   assign ys[6] = y6;
   assign ys[7] = y7;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: eight mailboxes, each either holding a word or empty.
   logic [31:0] m_y   [8];
   bit          m_full[8];
   int          m_ptr;
   bit          m_err;
   bit          m_init = 0;

   always @(posedge clk) begin
      int  dest;
      bit  free;
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            m_y[i]    = 32'h0;
            m_full[i] = 0;
         end
         m_ptr  = 0;
         m_err  = 0;
         m_init = 1;
      end else if (m_init) begin
         dest = rr_en ? m_ptr : int'(sel);
         free = !m_full[dest];
         for (int i = 0; i < 8; i++) begin
            if (ack[i]) begin
               if (m_full[i]) m_full[i] = 0;
               else           m_err     = 1;
            end
         end
         if (in_valid && free) begin
            m_y[dest]    = d;
            m_full[dest] = 1;
            if (rr_en) m_ptr = (m_ptr + 1) % 8;
         end
      end
   end

   // Compare process: mid-cycle, after registers and inputs have settled.
   always @(negedge clk) begin
      logic [7:0] exp_vld;
      int         dest;
      if (m_init) begin
         for (int i = 0; i < 8; i++) begin
            exp_vld[i] = m_full[i];
            chk($sformatf("model_y%0d", i), ys[i], m_y[i]);
         end
         dest = rr_en ? m_ptr : int'(sel);
         chk("model_vld", {24'h0, vld}, {24'h0, exp_vld});
         chk("model_ptr", {29'h0, ptr}, m_ptr);
         chk("model_err", {31'h0, err}, {31'h0, m_err});
         chk("model_in_ready", {31'h0, in_ready}, m_full[dest] ? 32'd0 : 32'd1);
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; d = '0; sel = '0; rr_en = 1'b0; ack = '0;
      cyc(2);
      reset = 1'b0;
      chk("ready_after_reset", {31'h0, in_ready}, 32'd1);
      chk("reset_vld", {24'h0, vld}, 32'h0);

      // Single steered write to channel 5
      sel = 3'd5; d = 32'hDEADBEEF; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk("s1_y5", y5, 32'hDEADBEEF);
      chk("s1_vld", {24'h0, vld}, 32'h20);
      chk("s1_err", {31'h0, err}, 32'd0);

      // Held word to full channel 5; ack in cycle k; accepted in k+1
      d = 32'hCAFEF00D; in_valid = 1'b1;
      chk("s2_stall_ready", {31'h0, in_ready}, 32'd0);
      cyc();
      ack = 8'h20;
      chk("s2_ack_cycle_ready", {31'h0, in_ready}, 32'd0);
      cyc();
      ack = 8'h00;
      chk("s2_vld_after_ack", {24'h0, vld}, 32'h00);
      chk("s2_y5_held", y5, 32'hDEADBEEF);
      chk("s2_ready_k1", {31'h0, in_ready}, 32'd1);
      cyc();
      in_valid = 1'b0;
      chk("s2_vld_k2", {24'h0, vld}, 32'h20);
      chk("s2_y5_new", y5, 32'hCAFEF00D);
      ack = 8'h20;
      cyc();
      ack = 8'h00;

      // Round-robin: eight words fill y0..y7; ninth waits for ack[0]
      rr_en = 1'b1;
      for (int w = 1; w <= 8; w++) begin
         d = w; in_valid = 1'b1;
         cyc();
      end
      in_valid = 1'b0;
      chk("rr_vld_full", {24'h0, vld}, 32'hFF);
      chk("rr_ptr_wrap", {29'h0, ptr}, 32'd0);
      for (int i = 0; i < 8; i++) chk($sformatf("rr_y%0d", i), ys[i], i + 1);
      d = 32'd9; in_valid = 1'b1;
      chk("rr_ninth_stall", {31'h0, in_ready}, 32'd0);
      cyc();
      chk("rr_ptr_held", {29'h0, ptr}, 32'd0);
      ack = 8'h01;
      cyc();
      ack = 8'h00;
      cyc();
      in_valid = 1'b0;
      chk("rr_y0_ninth", y0, 32'd9);
      chk("rr_y1_kept", y1, 32'd2);
      chk("rr_ptr_one", {29'h0, ptr}, 32'd1);

      // Pointer stalls on full channel 3 and does not skip ahead
      ack = 8'hFE; cyc();
      ack = 8'h01; cyc();
      ack = 8'h00;
      d = 32'hA; in_valid = 1'b1; cyc();
      d = 32'hB; cyc();
      in_valid = 1'b0;
      ack = 8'h06; cyc();
      ack = 8'h00;
      rr_en = 1'b0; sel = 3'd3; d = 32'h33; in_valid = 1'b1; cyc();
      chk("ptr_hold_sel_mode", {29'h0, ptr}, 32'd3);
      rr_en = 1'b1; d = 32'h44;
      chk("rr_stall_ready", {31'h0, in_ready}, 32'd0);
      cyc(3);
      chk("rr_stall_ptr", {29'h0, ptr}, 32'd3);
      chk("rr_stall_vld", {24'h0, vld}, 32'h08);
      chk("rr_stall_y3", y3, 32'h33);
      ack = 8'h08; cyc();
      ack = 8'h00;
      chk("rr_free_ready", {31'h0, in_ready}, 32'd1);
      cyc();
      in_valid = 1'b0;
      chk("rr_y3_new", y3, 32'h44);
      chk("rr_ptr_four", {29'h0, ptr}, 32'd4);
      chk("err_clean", {31'h0, err}, 32'd0);

      // Ack of an empty channel sets sticky err; valid ack still clears
      ack = 8'h08; cyc();
      ack = 8'h00;
      rr_en = 1'b0; sel = 3'd0; d = 32'h55; in_valid = 1'b1; cyc();
      in_valid = 1'b0;
      chk("err_pre_vld", {24'h0, vld}, 32'h01);
      ack = 8'h81; cyc();
      ack = 8'h00;
      chk("err_vld", {24'h0, vld}, 32'h00);
      chk("err_set", {31'h0, err}, 32'd1);
      cyc(2);
      chk("err_sticky", {31'h0, err}, 32'd1);

      // Reset over a full block with a word presented
      for (int s = 0; s < 8; s++) begin
         sel = s[2:0]; d = 32'h100 + s; in_valid = 1'b1;
         cyc();
      end
      chk("fill_vld", {24'h0, vld}, 32'hFF);
      reset = 1'b1; sel = 3'd0; d = 32'hDEAD0000;
      cyc();
      reset = 1'b0; in_valid = 1'b0;
      chk("rst_vld", {24'h0, vld}, 32'h00);
      chk("rst_ptr", {29'h0, ptr}, 32'd0);
      chk("rst_err", {31'h0, err}, 32'd0);
      for (int i = 0; i < 8; i++) chk($sformatf("rst_y%0d", i), ys[i], 32'h0);
      chk("rst_ready", {31'h0, in_ready}, 32'd1);
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
